// File: rtl/neureka_infeat_dbuf_if.sv
// rtl/neureka_infeat_dbuf_if.sv - feature stream and buffer read port bundle
interface neureka_infeat_dbuf_if #(
  parameter int NUM_WORDS  = 64,
  parameter int BLOCK_SIZE = 32,
  parameter int DW         = 8
);
  logic                              feat_valid_i;
  logic                              feat_ready_o;
  logic [BLOCK_SIZE*DW-1:0]          feat_data_i;
  logic                              buf_valid_o;
  logic                              buf_release_i;
  logic [NUM_WORDS*BLOCK_SIZE*DW-1:0] buf_data_o;

  modport master (
    output feat_valid_i, feat_data_i, buf_release_i,
    input  feat_ready_o, buf_valid_o, buf_data_o
  );

  modport slave (
    input  feat_valid_i, feat_data_i, buf_release_i,
    output feat_ready_o, buf_valid_o, buf_data_o
  );
endinterface

// File: rtl/neureka_infeat_dbuf.sv
// rtl/neureka_infeat_dbuf.sv - input feature double buffer with padding and 1x1 addressing
// Optional NEUREKA_INFEAT_DBUF_PINGPONG_EN: two banks; otherwise a single bank.
module neureka_infeat_dbuf #(
  parameter int NUM_WORDS  = 64,
  parameter int BLOCK_SIZE = 32,
  parameter int DW         = 8,
  parameter int ROW_W      = 8,
  parameter int PE_W       = 6
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic                         start_load_i,
  input  logic [$clog2(NUM_WORDS):0]   load_len_i,
  input  logic                         mode_1x1_i,
  input  logic [NUM_WORDS-1:0]         impl_pad_i,
  input  logic [NUM_WORDS-1:0]         expl_pad_i,
  input  logic [DW-1:0]                pad_value_i,
  input  logic                         broadcast_i,
  neureka_infeat_dbuf_if.slave         bus,
  output logic [1:0]                   state_o,
  output logic [1:0]                   full_o
);
  localparam int AW = $clog2(NUM_WORDS);
  localparam int LW = AW + 1;
  localparam int WW = BLOCK_SIZE * DW;
`ifdef NEUREKA_INFEAT_DBUF_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  localparam int NB = PP ? 2 : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2} state_e;

  state_e          state_q;
  logic            ready_q;
  logic            wr_bank_q, rd_bank_q;
  logic [1:0]      full_q, full_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [LW-1:0]   cnt_q, len_q, len_sat;
  logic [WW-1:0]   wdata;
  logic            beat, last, rel_fire;

  assign beat     = enable_i & ready_q & bus.feat_valid_i;
  assign last     = beat && ((cnt_q + LW'(1)) == len_q);
  assign rel_fire = enable_i & bus.buf_release_i & full_q[rd_bank_q];
  assign len_sat  = (load_len_i > LW'(NUM_WORDS)) ? LW'(NUM_WORDS) : load_len_i;

  // Completion and release hit different banks, so both can update in one cycle.
  always_comb begin
    full_d = full_q;
    if (rel_fire) full_d[rd_bank_q] = 1'b0;
    if (last)     full_d[wr_bank_q] = 1'b1;
  end

  // In 1x1 mode the tail of each row beyond PE_W words is skipped.
  always_comb begin
    waddr_d = waddr_q + AW'(1);
    if (mode_1x1_i && ((int'(waddr_q) % ROW_W) == (PE_W - 1)))
      waddr_d = waddr_q + AW'(ROW_W - PE_W + 1);
  end

  always_comb begin
    wdata = '0;
    for (int l = 0; l < BLOCK_SIZE; l++) begin
      if (impl_pad_i[waddr_q])      wdata[l*DW +: DW] = '0;
      else if (expl_pad_i[waddr_q]) wdata[l*DW +: DW] = pad_value_i;
      else if (broadcast_i)         wdata[l*DW +: DW] = bus.feat_data_i[DW-1:0];
      else                          wdata[l*DW +: DW] = bus.feat_data_i[l*DW +: DW];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      waddr_q   <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
    end else if (clear_i) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      waddr_q   <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
    end else if (enable_i) begin
      full_q <= full_d;
      if (rel_fire) rd_bank_q <= rd_bank_q ^ PP;
      case (state_q)
        IDLE: begin
          if (start_load_i && (load_len_i != '0)) begin
            len_q <= len_sat;
            if (full_d[wr_bank_q]) begin
              state_q <= WAIT;
            end else begin
              state_q <= LOAD;
              ready_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (!full_d[wr_bank_q]) begin
            state_q <= LOAD;
            ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (last) begin
            wr_bank_q <= wr_bank_q ^ PP;
            waddr_q   <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            ready_q   <= 1'b0;
          end else if (beat) begin
            waddr_q <= waddr_d;
            cnt_q   <= cnt_q + LW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic [WW-1:0] mem_q [NUM_WORDS];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int w = 0; w < NUM_WORDS; w++) mem_q[w] <= '0;
      end else if (clear_i) begin
        for (int w = 0; w < NUM_WORDS; w++) mem_q[w] <= '0;
      end else if (beat && (wr_bank_q == 1'(b))) begin
        mem_q[waddr_q] <= wdata;
      end
    end
  end

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_rd
    if (NB == 2) begin : g_pp
      assign bus.buf_data_o[k*WW +: WW] = rd_bank_q ? g_bank[1].mem_q[k] : g_bank[0].mem_q[k];
    end else begin : g_sp
      assign bus.buf_data_o[k*WW +: WW] = g_bank[0].mem_q[k];
    end
  end

  assign bus.feat_ready_o = ready_q & enable_i;
  assign bus.buf_valid_o  = full_q[rd_bank_q];
  assign state_o          = state_q;
  assign full_o           = full_q;
endmodule

// File: tb/tb_neureka_infeat_dbuf.sv
// tb/tb_neureka_infeat_dbuf.sv - randomized self-checking bench for neureka_infeat_dbuf
`timescale 1ns/1ps
module tb_neureka_infeat_dbuf;
  localparam int NW = 64, BS = 32, DW = 8, ROW_W = 8, PE_W = 6;
  localparam int WW = BS * DW;
`ifdef NEUREKA_INFEAT_DBUF_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic clk = 0, rst_n = 0, enable = 0, clear = 0, start = 0, mode = 0, bcast = 0;
  logic [6:0]    len = '0;
  logic [NW-1:0] impl = '0, expl = '0;
  logic [DW-1:0] padv = '0;
  logic [1:0]    state, full;

  neureka_infeat_dbuf_if #(.NUM_WORDS(NW), .BLOCK_SIZE(BS), .DW(DW)) bus();

  neureka_infeat_dbuf #(.NUM_WORDS(NW), .BLOCK_SIZE(BS), .DW(DW), .ROW_W(ROW_W), .PE_W(PE_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .start_load_i(start), .load_len_i(len), .mode_1x1_i(mode),
    .impl_pad_i(impl), .expl_pad_i(expl), .pad_value_i(padv), .broadcast_i(bcast),
    .bus(bus), .state_o(state), .full_o(full)
  );

  always #5 clk = ~clk;

  logic [WW-1:0] mdl_mem [2][NW];
  logic [1:0]    mdl_full;
  int            mdl_wr, mdl_rd;
  int            ncmp = 0, nfail = 0;

  task automatic chk1(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < NW; k++) mdl_mem[b][k] = '0;
    mdl_full = '0; mdl_wr = 0; mdl_rd = 0;
  endtask

  task automatic mdl_release();
    if (mdl_full[mdl_rd]) begin
      mdl_full[mdl_rd] = 1'b0;
      mdl_rd = PP ? 1 - mdl_rd : 0;
    end
  endtask

  function automatic int exp_addr(input int i);
    return mode ? (i / PE_W) * ROW_W + (i % PE_W) : i;
  endfunction

  function automatic logic [WW-1:0] exp_word(input int a, input logic [WW-1:0] d);
    if (impl[a]) return '0;
    if (expl[a]) return {BS{padv}};
    if (bcast)   return {BS{d[DW-1:0]}};
    return d;
  endfunction

  function automatic logic [WW-1:0] rnd_word();
    logic [WW-1:0] w;
    for (int j = 0; j < WW / 32; j++) w[j*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk_flags(input string tag);
    chk1({tag, "_full"}, full, mdl_full);
    chk1({tag, "_valid"}, bus.buf_valid_o, mdl_full[mdl_rd]);
  endtask

  task automatic chk_bank(input string tag);
    for (int k = 0; k < NW; k++)
      chkw($sformatf("%s_w%0d", tag, k), bus.buf_data_o[k*WW +: WW], mdl_mem[mdl_rd][k]);
  endtask

  task automatic pulse_start(input int n);
    start = 1'b1; len = 7'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic release_buf();
    bus.buf_release_i = 1'b1;
    if (enable) mdl_release();
    @(negedge clk);
    bus.buf_release_i = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    mdl_reset();
  endtask

  // Sends beats first..first+cnt-1 of a load of 'total' words; kind 0 gives data = address.
  task automatic feed(input int total, input int first, input int cnt, input int kind, input bit rel_last);
    int i = first, guard = 0, a;
    logic [WW-1:0] d;
    while (i < first + cnt && guard < 2000) begin
      guard++;
      if (bus.feat_ready_o === 1'b1 && $urandom_range(0, 3) != 0) begin
        a = exp_addr(i);
        d = (kind == 0) ? {BS{a[7:0]}} : rnd_word();
        bus.feat_valid_i = 1'b1; bus.feat_data_i = d;
        mdl_mem[mdl_wr][a] = exp_word(a, d);
        i++;
        if (rel_last && i == first + cnt) begin
          bus.buf_release_i = 1'b1;
          mdl_release();
        end
        if (i == total) begin
          mdl_full[mdl_wr] = 1'b1;
          mdl_wr = PP ? 1 - mdl_wr : 0;
        end
      end else begin
        bus.feat_valid_i = 1'b0; bus.feat_data_i = rnd_word();
      end
      @(negedge clk);
    end
    bus.feat_valid_i = 1'b0; bus.buf_release_i = 1'b0;
    chk1("feed_beats", i, first + cnt);
  endtask

  initial begin
    bus.feat_valid_i = 1'b0; bus.feat_data_i = '0; bus.buf_release_i = 1'b0;
    mdl_reset();
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_state", state, 2'd0);
    chk1("rst_ready", bus.feat_ready_o, 1'b0);
    chk_flags("rst");
    chk_bank("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Full linear load, data = address
    pulse_start(64);
    chk1("t1_state_load", state, 2'd1);
    feed(64, 0, 64, 0, 1'b0);
    chk1("t1_valid", bus.buf_valid_o, 1'b1);
    chk1("t1_state_idle", state, 2'd0);
    chk_flags("t1");
    chk_bank("t1");
    release_buf();
    chk_flags("t1_rel");

    pulse_start(0);
    chk1("len0_state", state, 2'd0);
    chk1("len0_ready", bus.feat_ready_o, 1'b0);

    do_clear();
    chk1("clr_state", state, 2'd0);
    chk_flags("clr");
    chk_bank("clr");

    // 1x1 row skipping
    mode = 1'b1;
    pulse_start(36);
    feed(36, 0, 36, 1, 1'b0);
    mode = 1'b0;
    chk_flags("t2");
    chk_bank("t2");
    release_buf();

    // Implicit and explicit padding
    do_clear();
    impl[3] = 1'b1; expl[3] = 1'b1; expl[4] = 1'b1; padv = 8'h7F;
    pulse_start(8);
    feed(8, 0, 8, 1, 1'b0);
    chkw("t3_w3", bus.buf_data_o[3*WW +: WW], '0);
    chkw("t3_w4", bus.buf_data_o[4*WW +: WW], {BS{8'h7F}});
    chk_bank("t3");
    release_buf();

    // Broadcast with random pad masks
    do_clear();
    impl = {$urandom, $urandom}; expl = {$urandom, $urandom};
    padv = 8'($urandom); bcast = 1'b1;
    pulse_start(20);
    feed(20, 0, 20, 1, 1'b0);
    chk_flags("t4");
    chk_bank("t4");
    bcast = 1'b0; impl = '0; expl = '0;
    release_buf();

    // Saturated length, then enable=0 blocks release
    do_clear();
    pulse_start(100);
    feed(64, 0, 64, 1, 1'b0);
    chk_flags("t5");
    chk_bank("t5");
    enable = 1'b0;
    release_buf();
    chk_flags("t5_dis");
    enable = 1'b1;
    release_buf();
    chk_flags("t5_rel");

    // enable=0 mid-load holds everything
    do_clear();
    pulse_start(6);
    feed(6, 0, 2, 1, 1'b0);
    enable = 1'b0;
    #1;
    chk1("dis_ready", bus.feat_ready_o, 1'b0);
    bus.feat_valid_i = 1'b1; bus.feat_data_i = rnd_word();
    start = 1'b1;
    repeat (3) @(negedge clk);
    bus.feat_valid_i = 1'b0; start = 1'b0;
    chk1("dis_state", state, 2'd1);
    enable = 1'b1;
    #1;
    feed(6, 2, 4, 1, 1'b0);
    chk_flags("dis");
    chk_bank("dis");
    release_buf();

    // Bank full handling
    do_clear();
`ifdef NEUREKA_INFEAT_DBUF_PINGPONG_EN
    pulse_start(4); feed(4, 0, 4, 1, 1'b0);
    pulse_start(4); feed(4, 0, 4, 1, 1'b0);
    chk1("pp_full11", full, 2'b11);
    pulse_start(4);
    chk1("pp_wait", state, 2'd2);
    repeat (2) @(negedge clk);
    chk1("pp_wait_hold", state, 2'd2);
    release_buf();
    chk1("pp_load", state, 2'd1);
    feed(4, 0, 4, 1, 1'b1);
    chk1("pp_same_cycle", full, 2'b01);
    chk_flags("pp");
    chk_bank("pp");
`else
    pulse_start(4); feed(4, 0, 4, 1, 1'b0);
    chk1("sb_full", full, 2'b01);
    pulse_start(4);
    chk1("sb_wait", state, 2'd2);
    repeat (2) @(negedge clk);
    chk1("sb_wait_hold", state, 2'd2);
    chk1("sb_wait_ready", bus.feat_ready_o, 1'b0);
    release_buf();
    chk1("sb_load", state, 2'd1);
    feed(4, 0, 4, 1, 1'b0);
    chk_flags("sb");
    chk_bank("sb");
`endif

    // Reset in the middle of a load
    do_clear();
    pulse_start(64);
    feed(64, 0, 10, 0, 1'b0);
    rst_n = 1'b0;
    #1;
    mdl_reset();
    chk1("mr_state", state, 2'd0);
    chk1("mr_ready", bus.feat_ready_o, 1'b0);
    chk_flags("mr");
    chk_bank("mr");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(8);
    feed(8, 0, 8, 0, 1'b0);
    chk_flags("mr2");
    chk_bank("mr2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
